// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: accepts key/pt, restarts key expansion, steps rounds 0..NR, holds ct.
// Optional build macro AES_ROUND_CTRL_ABORT_EN adds the abort/aborted ports.
module aes_round_ctrl #(
    parameter int NR = 10,
    parameter int W  = 128
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] key,
    input  logic [W-1:0] pt,
    output logic         ke_restart,
    output logic [W-1:0] ke_key,
    output logic         dp_load,
    output logic [W-1:0] dp_pt,
    output logic [3:0]   round,
    output logic         last_round,
    input  logic [W-1:0] dp_result,
    output logic         out_valid,
    input  logic         out_ready,
`ifdef AES_ROUND_CTRL_ABORT_EN
    output logic [W-1:0] ct,
    input  logic         abort,
    output logic         aborted
`else
    output logic [W-1:0] ct
`endif
);

    // Round index is 4 bits wide, so NR must not exceed 15.
    localparam logic [3:0] NR_L = 4'(NR);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        ROUND,
        HOLD
    } state_t;

    state_t state;

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            round      <= 4'd0;
            last_round <= 1'b0;
            ke_restart <= 1'b0;
            dp_load    <= 1'b0;
            ke_key     <= '0;
            dp_pt      <= '0;
            ct         <= '0;
            out_valid  <= 1'b0;
`ifdef AES_ROUND_CTRL_ABORT_EN
            aborted    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments make every register sample pre-edge values;
            // blocking ones here would make the result depend on statement order.
            ke_restart <= 1'b0;
            dp_load    <= 1'b0;
`ifdef AES_ROUND_CTRL_ABORT_EN
            aborted    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ke_key     <= key;
                        dp_pt      <= pt;
                        ke_restart <= 1'b1;
                        state      <= INIT;
                    end
                end
                INIT: begin
                    state      <= ROUND;
                    round      <= 4'd0;
                    dp_load    <= 1'b1;
                    last_round <= (NR_L == 4'd0);
                end
                ROUND: begin
                    if (last_round) begin
                        ct         <= dp_result;
                        out_valid  <= 1'b1;
                        state      <= HOLD;
                        round      <= 4'd0;
                        last_round <= 1'b0;
                    end else begin
                        round      <= round + 4'd1;
                        last_round <= ((round + 4'd1) == NR_L);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef AES_ROUND_CTRL_ABORT_EN
            // Abort overrides whatever the in-flight block would have done this edge.
            if (abort && (state == INIT || state == ROUND)) begin
                state      <= IDLE;
                round      <= 4'd0;
                last_round <= 1'b0;
                dp_load    <= 1'b0;
                ke_restart <= 1'b0;
                out_valid  <= 1'b0;
                ct         <= ct;
                aborted    <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl with a behavioural AES key-expansion/round datapath attached.
module tb_aes_round_ctrl;

    localparam logic [127:0] KEY_C  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [43:0]  RSEQ   = 44'h0123456789a;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [127:0] key_i, pt_i, ke_key, dp_pt, dp_result, ct;
    logic         ke_restart, dp_load, last_round;
    logic [3:0]   round;
`ifdef AES_ROUND_CTRL_ABORT_EN
    logic         abort, aborted;
`endif

    int tests  = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_round_ctrl #(.NR(10), .W(128)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .key        (key_i),
        .pt         (pt_i),
        .ke_restart (ke_restart),
        .ke_key     (ke_key),
        .dp_load    (dp_load),
        .dp_pt      (dp_pt),
        .round      (round),
        .last_round (last_round),
        .dp_result  (dp_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef AES_ROUND_CTRL_ABORT_EN
        .ct         (ct),
        .abort      (abort),
        .aborted    (aborted)
`else
        .ct         (ct)
`endif
    );

    // ---------------- AES environment model ----------------
    logic [7:0] sbox_t [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h00;
        for (int i = 1; i < 256; i++)
            if (gmul(a, 8'(i)) == 8'h01) inv = 8'(i);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] bt(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = sbox_t[bt(s, r + 4*((c + r) % 4))];
        return o;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = bt(s, 4*c); a1 = bt(s, 4*c+1); a2 = bt(s, 4*c+2); a3 = bt(s, 4*c+3);
            o[127-8*(4*c)   -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            o[127-8*(4*c+1) -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            o[127-8*(4*c+3) -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
        return o;
    endfunction

    function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sbox_t[k[23:16]], sbox_t[k[15:8]], sbox_t[k[7:0]], sbox_t[k[31:24]]} ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    logic [127:0] rk, st, s_in;
    logic [7:0]   rcon;

    initial for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));

    // Key expansion: raw key the cycle after restart, then one round key per cycle.
    always @(posedge clk) begin
        if (ke_restart) begin
            rk   <= ke_key;
            rcon <= 8'h01;
        end else begin
            rk   <= key_next(rk, rcon);
            rcon <= gmul(rcon, 8'h02);
        end
        st <= dp_result;
    end

    always_comb begin
        s_in = dp_load ? dp_pt : st;
        if (dp_load)         dp_result = s_in ^ rk;
        else if (last_round) dp_result = sub_shift(s_in) ^ rk;
        else                 dp_result = mix(sub_shift(s_in)) ^ rk;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full block: accept, watch the round walk, check ct, then hold for `hold` cycles.
    task automatic run_block(input logic [127:0] k, input logic [127:0] p, input logic [127:0] e,
                             input int hold, input bit poke, input string tag);
        int t_acc;
        logic [43:0] obs;
        bit done;
        @(negedge clk);
        check({tag, ".in_ready_idle"}, 128'(in_ready), 128'd1);
        key_i = k; pt_i = p; in_valid = 1'b1; out_ready = (hold == 0);
        t_acc = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, ".ke_restart"}, 128'(ke_restart), 128'd1);
        check({tag, ".ke_key"}, ke_key, k);
        check({tag, ".dp_pt"}, dp_pt, p);
        obs = '0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (out_valid) done = 1'b1;
            else begin
                obs = {obs[39:0], round};
                if (cyc - t_acc == 1)  check({tag, ".dp_load"}, 128'(dp_load), 128'd1);
                if (cyc - t_acc == 10) check({tag, ".last_round_r9"}, 128'(last_round), 128'd0);
                if (cyc - t_acc == 11) check({tag, ".last_round_r10"}, 128'(last_round), 128'd1);
                if (poke && cyc - t_acc == 5) begin
                    in_valid = 1'b1; key_i = ~k; pt_i = ~p;
                end
                if (poke && cyc - t_acc == 6) begin
                    in_valid = 1'b0;
                    check({tag, ".ke_key_busy"}, ke_key, k);
                    check({tag, ".dp_pt_busy"}, dp_pt, p);
                end
            end
        end
        check({tag, ".latency"}, 128'(cyc - t_acc), 128'd12);
        check({tag, ".round_seq"}, 128'(obs), 128'(RSEQ));
        check({tag, ".ct"}, ct, e);
        check({tag, ".ke_key_hold"}, ke_key, k);
        for (int h = 0; h < hold; h++) begin
            check({tag, ".hold_valid"}, 128'(out_valid), 128'd1);
            check({tag, ".hold_ct"}, ct, e);
            check({tag, ".hold_in_ready"}, 128'(in_ready), 128'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".drain_valid"}, 128'(out_valid), 128'd0);
        check({tag, ".drain_in_ready"}, 128'(in_ready), 128'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".out_valid"}, 128'(out_valid), 128'd0);
        check({tag, ".ct"}, ct, 128'd0);
        check({tag, ".ke_key"}, ke_key, 128'd0);
        check({tag, ".dp_pt"}, dp_pt, 128'd0);
        check({tag, ".round"}, 128'(round), 128'd0);
        check({tag, ".flags"}, 128'({ke_restart, dp_load, last_round}), 128'd0);
    endtask

    initial begin
        int acc [2];
        int nacc, nct;
        logic [127:0] cts [2];
        logic [87:0] obs88;
        bit found;

        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; key_i = '0; pt_i = '0;
`ifdef AES_ROUND_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        #3;
        check_reset_values("por");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("por.in_ready", 128'(in_ready), 128'd1);

        // FIPS-197 C.1 with a 5-cycle output stall, then B vector with a busy-time poke.
        run_block(KEY_C, PT_C, CT_C, 5, 1'b0, "c1");
        run_block(KEY_B, PT_B, CT_B, 0, 1'b1, "poke");

        // Back-to-back with in_valid and out_ready held high.
        acc[0] = 0; acc[1] = 0; nacc = 0; nct = 0; obs88 = '0;
        cts[0] = '0; cts[1] = '0;
        @(negedge clk);
        key_i = KEY_C; pt_i = PT_C; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 80 && nct < 2; i++) begin
            if (nacc == 1 && key_i == KEY_C) begin key_i = KEY_B; pt_i = PT_B; end
            if (in_valid && in_ready && nacc < 2) begin acc[nacc] = cyc + 1; nacc++; end
            if (dp_load || round != 4'd0) obs88 = {obs88[83:0], round};
            if (out_valid) begin cts[nct] = ct; nct++; end
            if (nct < 2) @(negedge clk);
        end
        in_valid = 1'b0;
        check("b2b.accept_gap", 128'(acc[1] - acc[0]), 128'd14);
        check("b2b.ct0", cts[0], CT_C);
        check("b2b.ct1", cts[1], CT_B);
        check("b2b.round_seq", 128'(obs88), 128'({RSEQ, RSEQ}));
        @(negedge clk);
        out_ready = 1'b0;
        check("b2b.in_ready", 128'(in_ready), 128'd1);

        // Asynchronous reset mid-block at round 5.
        @(negedge clk);
        key_i = KEY_C; pt_i = PT_C; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (round == 4'd5) found = 1'b1;
        end
        check("arst.reached_r5", 128'(found), 128'd1);
        #2 reset = 1'b0;
        #1;
        check_reset_values("arst");
        @(negedge clk);
        reset = 1'b1;
        run_block(KEY_B, PT_B, CT_B, 0, 1'b0, "post_rst");

`ifdef AES_ROUND_CTRL_ABORT_EN
        // Abort at round 3: back to IDLE, one-cycle aborted pulse, no output.
        @(negedge clk);
        key_i = KEY_B; pt_i = PT_B; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (round == 4'd3) found = 1'b1;
        end
        check("abort.reached_r3", 128'(found), 128'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort.aborted", 128'(aborted), 128'd1);
        check("abort.in_ready", 128'(in_ready), 128'd1);
        check("abort.round", 128'(round), 128'd0);
        @(negedge clk);
        check("abort.pulse_end", 128'(aborted), 128'd0);
        found = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) found = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("abort.no_out_valid", 128'(found), 128'd0);
        run_block(KEY_C, PT_C, CT_C, 0, 1'b0, "post_abort");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
